// File: rtl/row_sequencer.sv
// ---------------------------------------------------------------------------
// row_sequencer
//
// Walks the row multiplier across every output row (neuron) of one
// fully-connected layer. For each row it presents the row index, launches the
// multiplier, waits for the row sum, saturates it if the multiplier reports
// overflow, and writes it to the result buffer. A running signed argmax and a
// sticky overflow flag are kept across the layer for the top-level controller.
//
// Ports
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   start        begin a layer (only accepted while idle)
//   abort        request an early stop after the row in flight completes
//   busy         high whenever the sequencer is not idle
//   layer_done   one-cycle pulse: every row of the layer has been stored
//   aborted      one-cycle pulse: the layer was stopped early by abort
//   row_select   row index presented to the multiplier
//   begin_mult   one-cycle launch pulse to the multiplier
//   done_row     multiplier finished the row; row_result/overflow valid
//   row_result   signed row sum from the multiplier
//   overflow     row sum overflowed
//   res_wr_en    result buffer write strobe
//   res_wr_addr  result buffer address (the row index)
//   res_wr_data  stored, possibly saturated, row result
//   ovf_any      sticky: some row of this layer overflowed
//   best_row     index of the largest stored result
//   best_value   largest stored result
// ---------------------------------------------------------------------------
module row_sequencer #(
    parameter int          NUM_ROWS = 10,
    parameter logic [31:0] SAT_POS  = 32'h7FFF_FFFF,
    parameter logic [31:0] SAT_NEG  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        layer_done,
    output logic        aborted,
    output logic [3:0]  row_select,
    output logic        begin_mult,
    input  logic        done_row,
    input  logic [31:0] row_result,
    input  logic        overflow,
    output logic        res_wr_en,
    output logic [3:0]  res_wr_addr,
    output logic [31:0] res_wr_data,
    output logic        ovf_any,
    output logic [3:0]  best_row,
    output logic [31:0] best_value
);

    localparam int         DATA_W   = 32;
    localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, STORE, FINISH} state_t;

    state_t                    state;
    state_t                    state_next;
    logic [3:0]                cur_row;
    logic signed [DATA_W-1:0]  data_q;
    logic                      ovf_q;
    logic                      ovf_any_q;
    logic [3:0]                best_row_q;
    logic signed [DATA_W-1:0]  best_value_q;
    logic                      abort_pend;
    logic                      aborted_q;

    // An overflowed sum has wrapped, so its sign bit is the opposite of the
    // true sign: a negative-looking sum came from a positive overflow.
    function automatic logic signed [DATA_W-1:0] saturate(
        input logic signed [DATA_W-1:0] sum,
        input logic                     ovf
    );
        if (!ovf)
            return sum;
        else if (sum[DATA_W-1])
            return SAT_POS;
        else
            return SAT_NEG;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (done_row) state_next = STORE;
            STORE: begin
                // The last row always completes the layer, even if an abort
                // arrived while it was in flight.
                if (cur_row == LAST_ROW)
                    state_next = FINISH;
                else if (abort_pend)
                    state_next = IDLE;
                else
                    state_next = LAUNCH;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cur_row      <= '0;
            data_q       <= '0;
            ovf_q        <= 1'b0;
            ovf_any_q    <= 1'b0;
            best_row_q   <= '0;
            best_value_q <= SAT_NEG;
            abort_pend   <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            // Abort is only remembered; the row in flight always finishes so
            // the multiplier is back in idle before this block goes idle.
            if (state != IDLE && abort)
                abort_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_row      <= '0;
                        ovf_any_q    <= 1'b0;
                        best_row_q   <= '0;
                        best_value_q <= SAT_NEG;
                        abort_pend   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (done_row) begin
                        data_q <= saturate($signed(row_result), overflow);
                        ovf_q  <= overflow;
                    end
                end
                STORE: begin
                    ovf_any_q <= ovf_any_q | ovf_q;
                    // Row 0 seeds the argmax; strict compare keeps the lower
                    // index on ties.
                    if (cur_row == 4'd0 || data_q > best_value_q) begin
                        best_row_q   <= cur_row;
                        best_value_q <= data_q;
                    end
                    if (cur_row != LAST_ROW) begin
                        if (abort_pend)
                            aborted_q <= 1'b1;
                        else
                            cur_row <= cur_row + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign layer_done  = (state == FINISH);
    assign aborted     = aborted_q;
    assign row_select  = cur_row;
    assign begin_mult  = (state == LAUNCH);
    assign res_wr_en   = (state == STORE);
    assign res_wr_addr = cur_row;
    assign res_wr_data = data_q;
    assign ovf_any     = ovf_any_q;
    assign best_row    = best_row_q;
    assign best_value  = best_value_q;

endmodule

// File: tb/tb_row_sequencer.sv
// ---------------------------------------------------------------------------
// tb_row_sequencer
//
// Directed bench for row_sequencer. A small multiplier model answers each
// begin_mult with a table-driven row result after a row-dependent latency.
// The expected write stream and end-of-layer argmax/overflow summary are
// derived from the row table; literal expectations pin individual cases.
// ---------------------------------------------------------------------------
module tb_row_sequencer;

    localparam int          NR = 10;
    localparam logic [31:0] SP = 32'h7FFF_FFFF;
    localparam logic [31:0] SN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        layer_done;
    logic        aborted;
    logic [3:0]  row_select;
    logic        begin_mult;
    logic        done_row;
    logic [31:0] row_result;
    logic        overflow;
    logic        res_wr_en;
    logic [3:0]  res_wr_addr;
    logic [31:0] res_wr_data;
    logic        ovf_any;
    logic [3:0]  best_row;
    logic [31:0] best_value;

    always #5 clk = ~clk;

    row_sequencer #(.NUM_ROWS(NR), .SAT_POS(SP), .SAT_NEG(SN)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .busy(busy), .layer_done(layer_done), .aborted(aborted),
        .row_select(row_select), .begin_mult(begin_mult),
        .done_row(done_row), .row_result(row_result), .overflow(overflow),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
        .res_wr_data(res_wr_data), .ovf_any(ovf_any),
        .best_row(best_row), .best_value(best_value)
    );

    // Row table served by the multiplier model
    logic [31:0] tbl_res [16];
    logic        tbl_ovf [16];
    int          lat_base     = 0;
    logic        stray_done   = 1'b0;
    logic        mult_collide;

    int          checks   = 0;
    int          failures = 0;
    logic [3:0]  exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    logic [31:0] wr_log [16];
    int          wr_count = 0, bm_count = 0, ld_count = 0, ab_count = 0;
    int          s_wr, s_bm, s_ld, s_ab;
    logic        prev_bm  = 1'b0;

    // Multiplier model: launch on begin_mult, one done cycle after the
    // latency, then idle. A launch during busy or done would be lost.
    initial begin : mult_model
        int         cnt;
        logic       busy_m;
        logic [3:0] r_m;
        done_row     = 1'b0;
        row_result   = '0;
        overflow     = 1'b0;
        mult_collide = 1'b0;
        busy_m       = 1'b0;
        cnt          = 0;
        r_m          = '0;
        forever begin
            @(posedge clk);
            #1;
            done_row = 1'b0;
            if (!n_rst) begin
                busy_m = 1'b0;
            end else begin
                if (stray_done) begin
                    done_row   = 1'b1;
                    row_result = 32'h7000_0000;
                    overflow   = 1'b1;
                end
                if (busy_m) begin
                    if (cnt == 0) begin
                        done_row   = 1'b1;
                        row_result = tbl_res[r_m];
                        overflow   = tbl_ovf[r_m];
                        busy_m     = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (begin_mult) begin
                    if (busy_m || done_row) mult_collide = 1'b1;
                    busy_m = 1'b1;
                    r_m    = row_select;
                    cnt    = (int'(row_select) + lat_base) % 4;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] sat_m(input logic [31:0] r, input logic o);
        if (!o) return r;
        return r[31] ? SP : SN;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the expected write stream and pulse rules
    task automatic compare_cycle();
        logic [3:0]  ea;
        logic [31:0] ed;
        if (!n_rst) begin
            prev_bm = 1'b0;
            return;
        end
        if (res_wr_en) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0d data %h required no write", res_wr_addr, res_wr_data);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check32("wr_addr", {28'b0, res_wr_addr}, {28'b0, ea});
                check32("wr_data", res_wr_data, ed);
            end
            check32("busy_during_write", 32'(busy), 32'd1);
            wr_log[res_wr_addr] = res_wr_data;
            wr_count++;
        end
        if (begin_mult) begin
            check32("begin_mult_width", 32'(prev_bm), 32'd0);
            bm_count++;
        end
        prev_bm = begin_mult;
        if (layer_done) ld_count++;
        if (aborted)    ab_count++;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_wr = wr_count; s_bm = bm_count; s_ld = ld_count; s_ab = ab_count;
    endtask

    task automatic push_expect(input int n);
        for (int r = 0; r < n; r++) begin
            exp_addr_q.push_back(4'(r));
            exp_data_q.push_back(sat_m(tbl_res[r], tbl_ovf[r]));
        end
    endtask

    task automatic start_layer();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL %s_idle_timeout: busy still 1 after %0d cycles, required 0", tag, n);
        end
        tick();
    endtask

    task automatic wait_launch(input string tag, input logic [3:0] row);
        int n;
        n = 0;
        while (!(begin_mult && row_select == row) && n < 3000) begin
            tick();
            n++;
        end
        if (!(begin_mult && row_select == row)) begin
            checks++;
            failures++;
            $display("FAIL %s_launch_timeout: no launch of row %0d, required one", tag, row);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_busy"},        32'(busy),        32'd0);
        check32({tag, "_layer_done"},  32'(layer_done),  32'd0);
        check32({tag, "_aborted"},     32'(aborted),     32'd0);
        check32({tag, "_row_select"},  32'(row_select),  32'd0);
        check32({tag, "_begin_mult"},  32'(begin_mult),  32'd0);
        check32({tag, "_res_wr_en"},   32'(res_wr_en),   32'd0);
        check32({tag, "_res_wr_addr"}, 32'(res_wr_addr), 32'd0);
        check32({tag, "_res_wr_data"}, res_wr_data,      32'd0);
        check32({tag, "_ovf_any"},     32'(ovf_any),     32'd0);
        check32({tag, "_best_row"},    32'(best_row),    32'd0);
        check32({tag, "_best_value"},  best_value,       SN);
    endtask

    // End-of-layer summary compared with the argmax of the stored rows
    task automatic check_layer(input string tag, input int n, input int exp_ld, input int exp_ab);
        logic signed [31:0] bv;
        logic signed [31:0] d;
        int                 bi;
        logic               ov;
        bv = sat_m(tbl_res[0], tbl_ovf[0]);
        bi = 0;
        ov = tbl_ovf[0];
        for (int r = 1; r < n; r++) begin
            d = sat_m(tbl_res[r], tbl_ovf[r]);
            if (d > bv) begin
                bv = d;
                bi = r;
            end
            ov = ov | tbl_ovf[r];
        end
        check32({tag, "_writes"},      wr_count - s_wr, n);
        check32({tag, "_begin_mults"}, bm_count - s_bm, n);
        check32({tag, "_layer_dones"}, ld_count - s_ld, exp_ld);
        check32({tag, "_aborts"},      ab_count - s_ab, exp_ab);
        check32({tag, "_best_row"},    32'(best_row), bi);
        check32({tag, "_best_value"},  best_value, bv);
        check32({tag, "_ovf_any"},     32'(ovf_any), 32'(ov));
        check32({tag, "_busy_end"},    32'(busy), 32'd0);
        check32({tag, "_writes_left"}, exp_addr_q.size(), 0);
        check32({tag, "_mult_collide"}, 32'(mult_collide), 32'd0);
    endtask

    task automatic set_ramp(input int step);
        for (int r = 0; r < 16; r++) begin
            tbl_res[r] = step * r;
            tbl_ovf[r] = 1'b0;
        end
    endtask

    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_ramp(100);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        n_rst = 1'b1;
        tick();

        // 1: ramp 0,100..900 with a start pulse while busy
        lat_base = 0;
        set_ramp(100);
        push_expect(NR);
        snap();
        start_layer();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t1");
        check_layer("t1", NR, 1, 0);
        check32("t1_best_row_lit",   32'(best_row), 32'd9);
        check32("t1_best_value_lit", best_value,    32'd900);

        // done_row while idle must be ignored
        snap();
        stray_done = 1'b1;
        repeat (2) tick();
        stray_done = 1'b0;
        repeat (3) tick();
        check32("stray_writes", wr_count - s_wr, 0);
        check32("stray_busy",   32'(busy), 32'd0);
        check32("stray_best_value_held", best_value, 32'd900);

        // 2: tie keeps the lower index
        lat_base = 1;
        for (int r = 0; r < 16; r++) begin
            tbl_res[r] = 2;
            tbl_ovf[r] = 1'b0;
        end
        tbl_res[0] = 5; tbl_res[1] = -3; tbl_res[2] = 7; tbl_res[3] = 7;
        push_expect(NR);
        snap();
        start_layer();
        wait_idle("t2");
        check_layer("t2", NR, 1, 0);
        check32("t2_best_row_lit",   32'(best_row), 32'd2);
        check32("t2_best_value_lit", best_value,    32'd7);

        // 3: saturation in both directions
        lat_base = 2;
        set_ramp(10);
        tbl_res[4] = 32'h8000_0001; tbl_ovf[4] = 1'b1;
        tbl_res[6] = 32'h0000_0005; tbl_ovf[6] = 1'b1;
        push_expect(NR);
        snap();
        start_layer();
        wait_idle("t3");
        check_layer("t3", NR, 1, 0);
        check32("t3_row4_sat_pos", wr_log[4], 32'h7FFF_FFFF);
        check32("t3_row6_sat_neg", wr_log[6], 32'h8000_0000);
        check32("t3_ovf_any_lit",  32'(ovf_any),  32'd1);
        check32("t3_best_row_lit", 32'(best_row), 32'd4);

        // 4: all negative, argmax seeded from row 0
        lat_base = 3;
        for (int r = 0; r < 16; r++) begin
            tbl_res[r] = -(10 * (r + 1));
            tbl_ovf[r] = 1'b0;
        end
        push_expect(NR);
        snap();
        start_layer();
        wait_idle("t4");
        check_layer("t4", NR, 1, 0);
        check32("t4_best_row_lit",   32'(best_row), 32'd0);
        check32("t4_best_value_lit", best_value,    32'hFFFF_FFF6);

        // 5: abort during row 3 WAIT, then a clean full run
        lat_base = 2;
        set_ramp(100);
        tbl_ovf[1] = 1'b1;
        push_expect(4);
        snap();
        start_layer();
        wait_launch("t5", 4'd3);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle("t5");
        check_layer("t5", 4, 0, 1);
        check32("t5_row3_stored", wr_log[3], 32'd300);
        check32("t5_row1_sat",    wr_log[1], SN);
        check32("t5_ovf_any_lit", 32'(ovf_any), 32'd1);
        set_ramp(100);
        push_expect(NR);
        snap();
        start_layer();
        check32("t5_ovf_any_cleared", 32'(ovf_any), 32'd0);
        wait_idle("t5b");
        check_layer("t5b", NR, 1, 0);

        // 6: reset in WAIT of row 5 with start held across release
        lat_base = 1;
        set_ramp(100);
        tbl_ovf[2] = 1'b1;
        push_expect(5);
        snap();
        start_layer();
        wait_launch("t6", 4'd5);
        tick();
        start = 1'b1;
        n_rst = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        repeat (2) tick();
        check32("t6_pre_writes",  wr_count - s_wr, 5);
        check32("t6_writes_left", exp_addr_q.size(), 0);
        check32("t6_no_done",     ld_count - s_ld, 0);
        check32("t6_no_abort",    ab_count - s_ab, 0);
        tbl_ovf[2] = 1'b0;
        push_expect(NR);
        snap();
        n_rst = 1'b1;
        tick();
        check32("t6_relaunch_begin", 32'(begin_mult), 32'd1);
        check32("t6_relaunch_row",   32'(row_select), 32'd0);
        start = 1'b0;
        wait_idle("t6");
        check_layer("t6", NR, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
